// File: rtl/maf_pkg.sv
// Shared MAF datapath definitions: result/LZC widths and the cont codes
// carried in the sideband so stage 4, stage 5 and the normaliser agree.
package maf_pkg;

   localparam int PSIZE = 48;
   localparam int RES_W = PSIZE + 2;
   localparam int LZC_W = 6;

   // Inversion mode applied upstream; travels through stage 5 untouched.
   typedef enum logic [2:0] {
      CONT_LO_INV = 3'b000,
      CONT_HI_INV = 3'b001,
      CONT_NO_INV = 3'b010
   } cont_e;

endpackage

// File: rtl/maf_lzc.sv
// Combinational leading-zero counter, MSB-first; an all-zero input yields W.
// Shared by the CPA stage and the normaliser.
module maf_lzc
   import maf_pkg::*;
#(
   parameter int W  = RES_W,
   parameter int LW = LZC_W
) (
   input  logic [W-1:0]  d_i,
   output logic [LW-1:0] lzc_o,
   output logic          zero_o
);

   // NOTE: lzc_o gets its default before the loop, so every path assigns it and no latch is inferred.
   always_comb begin
      lzc_o = LW'(W);
      for (int i = 0; i < W; i++) begin
         if (d_i[i]) lzc_o = LW'(W - 1 - i);
      end
   end

   assign zero_o = ~|d_i;

endmodule

// File: rtl/t5_cpa_stage.sv
// MAF stage 5: resolves the CSA sum/carry pair with a two-cycle split
// carry-propagate add and attaches the leading-zero count for normalisation.
module t5_cpa_stage
   import maf_pkg::*;
#(
   parameter int PSIZE = 48,
   parameter int SPLIT = 25,
   parameter int SB_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PSIZE-1:0] sum_i,
   input  logic [PSIZE:0]   carry_i,
   input  logic [SB_W-1:0]  sb_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PSIZE+1:0] res_o,
   output logic [LZC_W-1:0] lzc_o,
   output logic             zero_o,
   output logic [SB_W-1:0]  sb_o
);

   localparam int HI_W = PSIZE + 2 - SPLIT;
   localparam int SH_W = PSIZE - SPLIT;
   localparam int CH_W = PSIZE + 1 - SPLIT;

   logic             s1_valid_q;
   logic [SPLIT-1:0] s1_lo_q;
   logic             s1_c1_q;
   logic [SH_W-1:0]  s1_sum_hi_q;
   logic [CH_W-1:0]  s1_carry_hi_q;
   logic [SB_W-1:0]  s1_sb_q;

   logic             out_valid_q;
   logic [PSIZE+1:0] res_q;
   logic [LZC_W-1:0] lzc_q;
   logic             zero_q;
   logic [SB_W-1:0]  sb_q;

   logic             s2_advance;
   logic             s1_advance;
   logic             in_xfer;
   logic [SPLIT:0]   low_d;
   logic [HI_W-1:0]  high_d;
   logic [PSIZE+1:0] res_d;
   logic [LZC_W-1:0] lzc_d;
   logic             zero_d;

   assign s2_advance = ~out_valid_q | out_ready;
   assign s1_advance = ~s1_valid_q | s2_advance;
   assign in_ready   = s1_advance;
   assign in_xfer    = in_valid & s1_advance;

   // Low segment resolves in S1; its carry-out joins the high segment in S2.
   assign low_d  = {1'b0, sum_i[SPLIT-1:0]} + {1'b0, carry_i[SPLIT-1:0]};
   assign high_d = HI_W'(s1_sum_hi_q) + HI_W'(s1_carry_hi_q) + HI_W'(s1_c1_q);
   assign res_d  = {high_d, s1_lo_q};

   maf_lzc #(
      .W  (PSIZE + 2),
      .LW (LZC_W)
   ) u_lzc (
      .d_i    (res_d),
      .lzc_o  (lzc_d),
      .zero_o (zero_d)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q    <= 1'b0;
         s1_lo_q       <= '0;
         s1_c1_q       <= 1'b0;
         s1_sum_hi_q   <= '0;
         s1_carry_hi_q <= '0;
         s1_sb_q       <= '0;
      end else if (s1_advance) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_lo_q       <= low_d[SPLIT-1:0];
            s1_c1_q       <= low_d[SPLIT];
            s1_sum_hi_q   <= sum_i[PSIZE-1:SPLIT];
            s1_carry_hi_q <= carry_i[PSIZE:SPLIT];
            s1_sb_q       <= sb_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         lzc_q       <= '0;
         zero_q      <= 1'b0;
         sb_q        <= '0;
      end else if (s2_advance) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            res_q  <= res_d;
            lzc_q  <= lzc_d;
            zero_q <= zero_d;
            sb_q   <= s1_sb_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign res_o     = res_q;
   assign lzc_o     = lzc_q;
   assign zero_o    = zero_q;
   assign sb_o      = sb_q;

endmodule

// File: tb/tb_t5_cpa_stage.sv
// Bench for t5_cpa_stage: directed corner cases, stall and reset scenarios,
// then randomized handshake traffic against an arithmetic reference queue.
module tb_t5_cpa_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] sum_i;
   logic [48:0] carry_i;
   logic [7:0]  sb_i;
   logic        out_valid;
   logic        out_ready;
   logic [49:0] res_o;
   logic [5:0]  lzc_o;
   logic        zero_o;
   logic [7:0]  sb_o;

   t5_cpa_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_i     (sum_i),
      .carry_i   (carry_i),
      .sb_i      (sb_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res_o     (res_o),
      .lzc_o     (lzc_o),
      .zero_o    (zero_o),
      .sb_o      (sb_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [49:0] res;
      logic [7:0]  sb;
      int          t;
   } item_t;

   item_t q[$];
   int    cyc = 0;
   int    n_out = 0;
   int    n_total = 0;
   int    n_pass = 0;
   int    n_fail = 0;
   bit    last_acc = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Leading zeros of a 50-bit value, scanning from the top bit.
   function automatic int ref_lzc(input logic [49:0] r);
      if (r == 50'd0) return 50;
      for (int b = 49; b >= 0; b--) begin
         if (r[b]) return 49 - b;
      end
      return 50;
   endfunction

   // One clock: check outputs at the falling edge against the reference
   // queue, then apply the handshake transfers at the rising edge.
   task automatic step();
      bit    xin;
      bit    xout;
      item_t it;
      @(negedge clk);
      check("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
      check("out_valid", 64'(out_valid), 64'((q.size() > 0) && (q[0].t < cyc)));
      if (out_valid && q.size() > 0) begin
         check("res", 64'(res_o), 64'(q[0].res));
         check("lzc", 64'(lzc_o), 64'(ref_lzc(q[0].res)));
         check("zero", 64'(zero_o), 64'(q[0].res == 50'd0));
         check("sb", 64'(sb_o), 64'(q[0].sb));
      end
      xin    = in_valid && in_ready;
      xout   = out_valid && out_ready;
      it.res = 50'(sum_i) + 50'(carry_i);
      it.sb  = sb_i;
      @(posedge clk);
      cyc++;
      if (xout && q.size() > 0) begin
         void'(q.pop_front());
         n_out++;
      end
      if (xin) begin
         it.t = cyc;
         q.push_back(it);
      end
      last_acc = xin;
      #1;
   endtask

   task automatic directed(input string tag, input logic [47:0] s, input logic [48:0] c,
                           input logic [7:0] sb, input logic [49:0] er, input int el, input bit ez);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      sum_i     = s;
      carry_i   = c;
      sb_i      = sb;
      step();
      in_valid = 1'b0;
      check({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
      step();
      check({tag, "_lat2_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_res"}, 64'(res_o), 64'(er));
      check({tag, "_lzc"}, 64'(lzc_o), 64'(el));
      check({tag, "_zero"}, 64'(zero_o), 64'(ez));
      check({tag, "_sb"}, 64'(sb_o), 64'(sb));
      step();
   endtask

   initial begin
      logic [63:0] r1;
      logic [63:0] r2;
      int          mode;
      int          out_base;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sum_i     = '0;
      carry_i   = '0;
      sb_i      = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_res", 64'(res_o), 64'(0));
      check("rst_lzc", 64'(lzc_o), 64'(0));
      check("rst_zero", 64'(zero_o), 64'(0));
      check("rst_sb", 64'(sb_o), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      directed("one_plus_one", 48'd1, 49'd1, 8'h5A, 50'd2, 48, 1'b0);
      directed("split_carry", 48'h000_01FF_FFFF, 49'd1, 8'h11, 50'h200_0000, 24, 1'b0);
      directed("max", 48'hFFFF_FFFF_FFFF, 49'h1_FFFF_FFFF_FFFF, 8'hA5, 50'h2_FFFF_FFFF_FFFE, 0, 1'b0);
      directed("all_zero", 48'd0, 49'd0, 8'h00, 50'd0, 50, 1'b1);

      // Four back-to-back inputs into a stalled output.
      out_base  = n_out;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      carry_i   = '0;
      sum_i     = 48'd1;
      sb_i      = 8'h01;
      step();
      sum_i = 48'd2;
      sb_i  = 8'h02;
      step();
      check("stall_in_ready_low", 64'(in_ready), 64'(0));
      check("stall_res_first", 64'(res_o), 64'(1));
      sum_i = 48'd3;
      sb_i  = 8'h03;
      step();
      step();
      check("stall_res_hold", 64'(res_o), 64'(1));
      check("stall_valid_hold", 64'(out_valid), 64'(1));
      out_ready = 1'b1;
      #1;
      check("stall_release_ready", 64'(in_ready), 64'(1));
      step();
      sum_i = 48'd4;
      sb_i  = 8'h04;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      check("stall_out_count", 64'(n_out - out_base), 64'(4));

      // Asynchronous reset with two results in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sum_i     = 48'd5;
      step();
      sum_i = 48'd6;
      step();
      in_valid = 1'b0;
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'(0));
      check("async_rst_res", 64'(res_o), 64'(0));
      check("async_rst_ready", 64'(in_ready), 64'(1));
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (3) step();
      directed("post_rst", 48'd7, 49'd9, 8'hC3, 50'd16, 45, 1'b0);

      // Randomized traffic with back-pressure; data holds until accepted.
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            mode     = int'($urandom_range(0, 4));
            r1       = {$urandom(), $urandom()};
            r2       = {$urandom(), $urandom()};
            case (mode)
               0: begin
                  sum_i   = 48'hFFFF_FFFF_FFFF;
                  carry_i = 49'h1_FFFF_FFFF_FFFF;
               end
               1: begin
                  sum_i   = '0;
                  carry_i = '0;
               end
               2: begin
                  sum_i   = 48'(r1[7:0]) << r2[5:0];
                  carry_i = 49'(r2[15:8]);
               end
               default: begin
                  sum_i   = r1[47:0];
                  carry_i = r2[48:0];
               end
            endcase
            sb_i = 8'($urandom());
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      check("drain_empty", 64'(q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/t5_cpa_stage.md
Name: t5_cpa_stage

Overview:
- Stage-5 pipeline block of the MAF datapath; consumes the redundant Sum/Carry pair produced by the stage-4 CSA.
- Resolves the pair with a carry-propagate add split over two pipeline cycles.
- Produces the leading-zero count and zero flag used by the normalisation stage.
- Valid/ready handshake on both sides; carries an opaque sideband word aligned with the data.

Parameters:
- PSIZE, 48, width of the CSA Sum input; Carry input is PSIZE+1 wide.
- SPLIT, 25, bit position where the add is split; low segment is [SPLIT-1:0], computed in pipeline stage 1.
- SB_W, 8, sideband width (cont code, sign, control bits), passed through unchanged.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  upstream data valid
- in_ready  out  1  block can accept this cycle
- sum_i  in  PSIZE  CSA sum vector
- carry_i  in  PSIZE+1  CSA carry vector, already shifted left by one
- sb_i  in  SB_W  sideband
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- res_o  out  PSIZE+2  resolved sum_i+carry_i (50 bits)
- lzc_o  out  6  leading zeros of res_o counted from bit PSIZE+1
- zero_o  out  1  res_o == 0
- sb_o  out  SB_W  sideband aligned with res_o

Behaviour:
- Reset: async on rst_n low. Clears s1_valid, s2_valid and out_valid to 0 immediately. res_o, lzc_o, zero_o and sb_o reset to 0. Any in-flight data is discarded.
- Pipeline: two register stages, S1 and S2. Latency is 2 cycles from input acceptance to out_valid. Throughput is 1 per cycle when out_ready=1.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - s2_advance = ~s2_valid | out_ready.
  - s1_advance = ~s1_valid | s2_advance.
  - in_ready = s1_advance (combinational).
- S1, on an input transfer:
  - low = sum_i[SPLIT-1:0] + carry_i[SPLIT-1:0], SPLIT+1 bits wide.
  - Register low[SPLIT-1:0] and the carry c1 = low[SPLIT].
  - Register the zero-extended high operands sum_i[PSIZE-1:SPLIT] and carry_i[PSIZE:SPLIT], plus sb_i.
  - Set s1_valid.
- S1 clear: if s1_advance and there is no input transfer, s1_valid clears.
- S2, on s2_advance with s1_valid:
  - high = sum_hi + carry_hi + c1, PSIZE+2-SPLIT bits.
  - res = {high, low}.
  - lzc computed combinationally on res.
  - Register res_o, lzc_o, zero_o and sb_o; set out_valid.
- S2 clear: if s2_advance with no s1_valid, out_valid clears.
- Stall: when out_valid=1 and out_ready=0, all S2 outputs hold stable and S1 holds if full. There is no bubble insertion; order is preserved and nothing is dropped or duplicated.
- Width: no truncation. Maximum result is (2^48-1)+(2^49-1) = 0x2_FFFF_FFFF_FFFE, which fits in 50 bits. carry_i[0] is added as given; the block does not depend on it being 0.
- lzc: counts zeros from bit 49 downward.
  - res=0 gives lzc_o=50 and zero_o=1.
  - Otherwise lzc_o = 49 - index of the highest set bit, and zero_o=0.
- Simultaneous input and output transfer while full: both occur in the same cycle, giving a full-rate flow-through.
- Reset released mid-stream: the first output appears 2 cycles after the first accepted input following release.

Decomposition:
- Shared MAF package holds:
  - PSIZE=48
  - RES_W=PSIZE+2
  - LZC_W=6
  - the cont encodings (3'b000 and 3'b001, low-/high-inversion modes; 3'b010) carried in the sideband, so stage 4, stage 5 and the normaliser agree.
- One sub-module: maf_lzc. It is a parameterised leading-zero counter (width RES_W, output LZC_W) and is purely combinational. The normaliser reuses it.

Test Plan:
- sum_i=1, carry_i=1, sb_i=8'h5A -> 2 cycles later res_o=2, lzc_o=48, zero_o=0, sb_o=8'h5A.
- sum_i=48'h000_01FF_FFFF, carry_i=1 (carry across the split) -> res_o=50'h200_0000, lzc_o=24.
- sum_i=48'hFFFF_FFFF_FFFF, carry_i=49'h1_FFFF_FFFF_FFFF -> res_o=50'h2_FFFF_FFFF_FFFE, lzc_o=0.
- sum_i=0, carry_i=0 -> res_o=0, lzc_o=50, zero_o=1.
- 4 back-to-back inputs (res 1,2,3,4) with out_ready=0 for cycles 2-5:
  - in_ready drops once S1 and S2 are both full.
  - Outputs emerge in order 1,2,3,4 with none lost or duplicated.
  - res_o is stable while stalled.
- Two valid transactions in flight, rst_n pulled low asynchronously mid-cycle:
  - out_valid drops to 0 before the next edge.
  - After release no stale result appears.
  - A new input yields its output exactly 2 cycles later.
